// File: rtl/com_to_fifo.sv
// com_to_fifo: UART 8N1 receiver that frames bytes into CRC-8 protected packets
// and pushes the data bytes into the shared FIFO via the fifoWe/isFifoBusy handshake.
module com_to_fifo #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned PKT_LEN      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx,
    input  logic       isFifoBusy,
    input  logic       isFifoFull,
    output logic [7:0] fifoDataIn,
    output logic       fifoWe,
    output logic [7:0] CRC,
    output logic [7:0] byteCount,
    output logic       packetDone,
    output logic       crcError,
    output logic       frameError,
    output logic       overrunError
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       PKT_LEN_B = 8'(PKT_LEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_meta;
    logic             rxs;
    logic [7:0]       crc;
    logic [7:0]       hold;
    logic             hold_valid;
    logic             byte_done_c;

    // One CRC-8 step over a whole byte: poly 0x07, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // A good stop bit is being sampled this cycle: shreg holds the finished byte.
    assign byte_done_c = enable && (state == STOP) && (cnt == BIT_LAST) && rxs;

    // Receive FSM: start detection, mid-bit sampling, stop check and break wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            frameError <= 1'b0;
        end else begin
            frameError <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state   <= START;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end
                    START: begin
                        if (cnt == HALF_LAST) begin
                            cnt   <= '0;
                            state <= rxs ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            shreg   <= {rxs, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt <= '0;
                            if (rxs) begin
                                state <= IDLE;
                            end else begin
                                frameError <= 1'b1;
                                state      <= BREAK;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    BREAK: begin
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Packet framing, CRC tracking, hold register and FIFO write handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifoDataIn   <= '0;
            fifoWe       <= 1'b0;
            CRC          <= '0;
            byteCount    <= '0;
            packetDone   <= 1'b0;
            crcError     <= 1'b0;
            overrunError <= 1'b0;
            crc          <= '0;
            hold         <= '0;
            hold_valid   <= 1'b0;
        end else begin
            fifoWe       <= 1'b0;
            packetDone   <= 1'b0;
            overrunError <= 1'b0;

            if (hold_valid && !isFifoBusy && !isFifoFull) begin
                fifoWe     <= 1'b1;
                fifoDataIn <= hold;
                hold_valid <= 1'b0;
            end

            if (byte_done_c) begin
                if (byteCount < PKT_LEN_B) begin
                    // Dropped bytes still advance the CRC and count to keep framing aligned.
                    crc       <= crc8_byte(crc, shreg);
                    byteCount <= byteCount + 8'd1;
                    if (isFifoFull || hold_valid) begin
                        overrunError <= 1'b1;
                    end else begin
                        hold       <= shreg;
                        hold_valid <= 1'b1;
                    end
                end else begin
                    CRC        <= shreg;
                    crcError   <= (shreg != crc);
                    packetDone <= 1'b1;
                    crc        <= '0;
                    byteCount  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_com_to_fifo.sv
// tb_com_to_fifo: directed bench for the UART-to-FIFO receiver (4 clk/bit, 2-byte packets).
module tb_com_to_fifo;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       rx;
    logic       isFifoBusy;
    logic       isFifoFull;
    logic [7:0] fifoDataIn;
    logic       fifoWe;
    logic [7:0] CRC;
    logic [7:0] byteCount;
    logic       packetDone;
    logic       crcError;
    logic       frameError;
    logic       overrunError;

    int tests;
    int fails;

    int we_count;
    int pkt_count;
    int ferr_count;
    int ovr_count;
    logic [7:0] wr_log [0:63];

    int we0, pkt0, ferr0, ovr0;

    com_to_fifo #(
        .CLKS_PER_BIT(CPB),
        .PKT_LEN     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rx          (rx),
        .isFifoBusy  (isFifoBusy),
        .isFifoFull  (isFifoFull),
        .fifoDataIn  (fifoDataIn),
        .fifoWe      (fifoWe),
        .CRC         (CRC),
        .byteCount   (byteCount),
        .packetDone  (packetDone),
        .crcError    (crcError),
        .frameError  (frameError),
        .overrunError(overrunError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one-cycle pulses and log every FIFO write.
    always @(negedge clk) begin
        if (!reset) begin
            if (fifoWe) begin
                wr_log[we_count[5:0]] <= fifoDataIn;
                we_count <= we_count + 1;
            end
            if (packetDone)   pkt_count  <= pkt_count + 1;
            if (frameError)   ferr_count <= ferr_count + 1;
            if (overrunError) ovr_count  <= ovr_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        we0   = we_count;
        pkt0  = pkt_count;
        ferr0 = ferr_count;
        ovr0  = ovr_count;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full 8N1 frame, LSB first, with selectable stop-bit level; called on a negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Start bit plus the first nbits data bits, leaving the frame unfinished.
    task automatic send_partial(input logic [7:0] b, input int nbits);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        enable     = 1'b1;
        rx         = 1'b1;
        isFifoBusy = 1'b0;
        isFifoFull = 1'b0;

        // Reset values
        idle(3);
        check("rst_fifoWe",     32'(fifoWe),       32'h0);
        check("rst_fifoDataIn", 32'(fifoDataIn),   32'h0);
        check("rst_CRC",        32'(CRC),          32'h0);
        check("rst_byteCount",  32'(byteCount),    32'h0);
        check("rst_packetDone", 32'(packetDone),   32'h0);
        check("rst_crcError",   32'(crcError),     32'h0);
        check("rst_frameError", 32'(frameError),   32'h0);
        check("rst_overrun",    32'(overrunError), 32'h0);
        reset = 1'b0;
        idle(4);

        // Single data byte
        snap();
        send_byte(8'h55, 1'b1);
        idle(10);
        check("t1_we_count",   32'(we_count - we0),    32'd1);
        check("t1_data",       32'(wr_log[we0[5:0]]),  32'h55);
        check("t1_fifoDataIn", 32'(fifoDataIn),        32'h55);
        check("t1_byteCount",  32'(byteCount),         32'd1);
        check("t1_ferr",       32'(ferr_count - ferr0), 32'd0);
        check("t1_ovr",        32'(ovr_count - ovr0),  32'd0);

        // Reset between frames clears packet state
        reset = 1'b1;
        idle(2);
        check("rst2_byteCount",  32'(byteCount),  32'h0);
        check("rst2_fifoDataIn", 32'(fifoDataIn), 32'h0);
        reset = 1'b0;
        idle(4);

        // Good packet, back-to-back frames
        snap();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h15, 1'b1);
        idle(10);
        check("t2_we_count",  32'(we_count - we0),          32'd2);
        check("t2_data0",     32'(wr_log[we0[5:0]]),        32'h01);
        check("t2_data1",     32'(wr_log[6'(we0 + 1)]),     32'h00);
        check("t2_pkt",       32'(pkt_count - pkt0),        32'd1);
        check("t2_CRC",       32'(CRC),                     32'h15);
        check("t2_crcError",  32'(crcError),                32'h0);
        check("t2_byteCount", 32'(byteCount),               32'd0);

        // Packet with wrong CRC
        snap();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h14, 1'b1);
        idle(10);
        check("t3_we_count",  32'(we_count - we0),   32'd2);
        check("t3_pkt",       32'(pkt_count - pkt0), 32'd1);
        check("t3_CRC",       32'(CRC),              32'h14);
        check("t3_crcError",  32'(crcError),         32'h1);
        check("t3_byteCount", 32'(byteCount),        32'd0);

        // Framing error then a good byte
        snap();
        send_byte(8'hFF, 1'b0);
        idle(10);
        check("t4_ferr",      32'(ferr_count - ferr0), 32'd1);
        check("t4_we_bad",    32'(we_count - we0),     32'd0);
        check("t4_bc_bad",    32'(byteCount),          32'd0);
        send_byte(8'hA3, 1'b1);
        idle(10);
        check("t4_we_good",   32'(we_count - we0),     32'd1);
        check("t4_data",      32'(wr_log[we0[5:0]]),   32'hA3);
        check("t4_byteCount", 32'(byteCount),          32'd1);

        // FIFO full: byte dropped but still counted
        snap();
        isFifoFull = 1'b1;
        send_byte(8'h7E, 1'b1);
        idle(10);
        isFifoFull = 1'b0;
        idle(5);
        check("t5_ovr",       32'(ovr_count - ovr0), 32'd1);
        check("t5_we_full",   32'(we_count - we0),   32'd0);
        check("t5_byteCount", 32'(byteCount),        32'd2);

        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(4);

        // FIFO busy: write deferred until busy drops
        snap();
        isFifoBusy = 1'b1;
        send_byte(8'h3C, 1'b1);
        idle(3);
        check("t5_we_busy",    32'(we_count - we0), 32'd0);
        check("t5_bc_busy",    32'(byteCount),      32'd1);
        isFifoBusy = 1'b0;
        idle(3);
        check("t5_we_after",   32'(we_count - we0),    32'd1);
        check("t5_data_after", 32'(wr_log[we0[5:0]]),  32'h3C);
        check("t5_ovr_busy",   32'(ovr_count - ovr0),  32'd0);

        // False start: one-cycle glitch
        snap();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        idle(20);
        check("t6_fs_we",   32'(we_count - we0),     32'd0);
        check("t6_fs_ferr", 32'(ferr_count - ferr0), 32'd0);
        check("t6_fs_pkt",  32'(pkt_count - pkt0),   32'd0);
        check("t6_fs_bc",   32'(byteCount),          32'd1);

        // Enable dropped mid-frame: silently abandoned
        snap();
        send_partial(8'h00, 3);
        enable = 1'b0;
        idle(6);
        rx = 1'b1;
        idle(10);
        enable = 1'b1;
        idle(5);
        check("t6_en_we",   32'(we_count - we0),     32'd0);
        check("t6_en_ferr", 32'(ferr_count - ferr0), 32'd0);
        check("t6_en_bc",   32'(byteCount),          32'd1);
        send_byte(8'h42, 1'b1);
        idle(10);
        check("t6_en_rec_we",   32'(we_count - we0),   32'd1);
        check("t6_en_rec_data", 32'(wr_log[we0[5:0]]), 32'h42);
        check("t6_en_rec_bc",   32'(byteCount),        32'd2);

        // Reset mid-frame
        snap();
        send_partial(8'h00, 3);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_we",       32'(fifoWe),     32'h0);
        check("t6_rst_bc",       32'(byteCount),  32'h0);
        check("t6_rst_data",     32'(fifoDataIn), 32'h0);
        check("t6_rst_CRC",      32'(CRC),        32'h0);
        check("t6_rst_crcError", 32'(crcError),   32'h0);
        rx = 1'b1;
        idle(10);
        reset = 1'b0;
        idle(10);
        check("t6_rst_we_after", 32'(we_count - we0), 32'd0);
        check("t6_rst_bc_after", 32'(byteCount),      32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
